// File: rtl/sha256_pkg.sv
// Shared constants, schedule FSM encoding and rotate helper for the SHA-256 core.
package sha256_pkg;

  localparam int WORD_W        = 32;
  localparam int NUM_MSG_WORDS = 16;
  localparam int NUM_ROUNDS    = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND,
    DONE
  } sched_state_t;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/sha256_small_sigma.sv
// Combinational small-sigma: SEL=0 gives sigma0, SEL=1 gives sigma1.
// Zero latency, no flow control.
module sha256_small_sigma
  import sha256_pkg::*;
#(
  parameter int SEL = 0
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  if (SEL == 0) begin : g_sigma0
    assign y = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  end else begin : g_sigma1
    assign y = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  end

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads W0..W15 (stallable via data_valid_i), then expands W16..W63 one per cycle.
// Words appear on w_o one cycle after acceptance/computation; no downstream backpressure.
module sha256_msg_schedule #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [WORD_W-1:0] data_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  output logic [WORD_W-1:0] w_o,
  output logic              w_valid_o,
  output logic [5:0]        t_o,
  output logic              busy_o,
  output logic              done_o
);

  import sha256_pkg::*;

  sched_state_t      state_q, state_d;
  logic [WORD_W-1:0] win_q [NUM_MSG_WORDS];
  logic [5:0]        t_q;

  logic              accept;
  logic              exp_fin;
  logic              issue_exp;
  logic              shift_en;
  logic [WORD_W-1:0] shift_word;
  logic [WORD_W-1:0] s0;
  logic [WORD_W-1:0] s1;
  logic [WORD_W-1:0] w_new;

  assign accept     = (state_q == LOAD) && data_valid_i;
  // W63 is on the output: EXPAND holds one extra cycle so busy_o covers it, but issues nothing.
  assign exp_fin    = w_valid_o && (t_o == 6'(NUM_ROUNDS - 1));
  assign issue_exp  = (state_q == EXPAND) && !exp_fin;
  assign shift_en   = accept || issue_exp;
  assign shift_word = accept ? data_i : w_new;

  sha256_small_sigma #(.SEL(0)) u_sigma0 (
    .x (win_q[1]),
    .y (s0)
  );

  sha256_small_sigma #(.SEL(1)) u_sigma1 (
    .x (win_q[14]),
    .y (s1)
  );

  // Slot 0 = W[t-16], slot 1 = W[t-15], slot 9 = W[t-7], slot 14 = W[t-2]
  assign w_new = s1 + win_q[9] + s0 + win_q[0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (accept && (t_q == 6'(NUM_MSG_WORDS - 1))) state_d = EXPAND;
      EXPAND:  if (exp_fin) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_MSG_WORDS; i++) begin
        win_q[i] <= '0;
      end
      t_q       <= '0;
      w_o       <= '0;
      w_valid_o <= 1'b0;
      t_o       <= '0;
    end else begin
      w_valid_o <= shift_en;
      if ((state_q == IDLE) && start) begin
        for (int i = 0; i < NUM_MSG_WORDS; i++) begin
          win_q[i] <= '0;
        end
        t_q <= '0;
      end else if (shift_en) begin
        for (int i = 0; i < NUM_MSG_WORDS - 1; i++) begin
          win_q[i] <= win_q[i+1];
        end
        win_q[NUM_MSG_WORDS-1] <= shift_word;
        w_o <= shift_word;
        t_o <= t_q;
        // Counter parks at 63; only a new start rewinds it.
        if (t_q != 6'(NUM_ROUNDS - 1)) begin
          t_q <= t_q + 6'd1;
        end
      end
    end
  end

  assign data_ready_o = (state_q == LOAD);
  assign busy_o       = (state_q == LOAD) || (state_q == EXPAND);
  assign done_o       = (state_q == DONE);

endmodule
